id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3, EX-stage occupancy in cycles of an EXE_MUL instruction (legal 1..15).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  branch taken; discard ID/EX contents
- freeze  in  1  global pipeline hold
- hazard  in  1  insert bubble instead of capturing ID
- B_in, S_in, wb_en_in, mem_read_in, mem_write_in  in  1 each  control-unit outputs
- exe_cmd_in  in  4  control-unit ExecuteCommand
- pc_in, val_rn_in, val_rm_in  in  32 each  PC+4 and operand values
- shift_operand_in  in  12  shifter operand field
- imm_in  in  1  immediate flag
- signed_imm24_in  in  24  branch offset
- dest_in  in  4  destination register
- B_out, S_out, wb_en_out, mem_read_out, mem_write_out, exe_cmd_out, pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out, signed_imm24_out, dest_out  out  same widths  registered copies
- stall_out  out  1  upstream hold request during multicycle MUL

Function
REQ-003 SHALL capture all *_in fields on each rising clk edge when no higher-priority event applies; latency ID->EX exactly 1 cycle.
REQ-004 Edge priority SHALL be: flush > freeze > MUL hold > hazard > capture.
REQ-005 flush SHALL clear every output to 0 and force state IDLE, cnt 0, aborting any MUL in progress.
REQ-006 freeze (without flush) SHALL hold all outputs, state and cnt unchanged.
REQ-007 hazard SHALL load B, S, wb_en, mem_read, mem_write, exe_cmd as 0 (bubble); data fields SHALL still load from inputs.
REQ-008 FSM states SHALL be IDLE and MUL_WAIT with 4-bit counter cnt.
REQ-009 IDLE: on a capture edge with exe_cmd_in == EXE_MUL (constants.v) and MUL_CYCLES > 1: cnt <= MUL_CYCLES-1, next state MUL_WAIT; otherwise stay IDLE.
REQ-010 MUL_WAIT: outputs SHALL hold, hazard and *_in ignored; each non-frozen edge decrements cnt; edge at which cnt reaches 0 transitions to IDLE while still holding.
REQ-011 stall_out SHALL be combinational, 1 exactly when state == MUL_WAIT; a MUL therefore occupies EX for MUL_CYCLES cycles with stall_out high for MUL_CYCLES-1 of them.
REQ-012 A MUL captured back-to-back after leaving MUL_WAIT SHALL restart the sequence with no gap cycle.
REQ-013 A MUL arriving with hazard asserted SHALL become a bubble and SHALL NOT enter MUL_WAIT.

Reset
REQ-014 rst_n low SHALL immediately (asynchronously) zero all outputs, state IDLE, cnt 0; stall_out 0.
REQ-015 Release SHALL take effect at the first rising clk with rst_n high; reset mid-MUL aborts it.

Configuration
REQ-016 Macro ID_EX_MUL_STALL_EN defined: multicycle MUL hold per REQ-008..REQ-013.
REQ-017 Macro undefined: no FSM or counter; EXE_MUL captured like any command; stall_out tied 0; MUL_CYCLES ignored.

Verification
REQ-018 Reset: rst_n low mid-cycle with outputs nonzero -> all outputs 0 before next edge.
REQ-019 Capture: exe_cmd_in=EXE_ADD, dest_in=4'h3, wb_en_in=1 -> next cycle exe_cmd_out=EXE_ADD, dest_out=3, wb_en_out=1, stall_out=0.
REQ-020 MUL (macro on, MUL_CYCLES=3): EXE_MUL captured at edge 0 -> stall_out=1 cycles 1-2, 0 cycle 3; outputs unchanged through edge 2; new instruction captured at edge 3.
REQ-021 Flush during MUL_WAIT (cnt=1) -> next cycle all outputs 0, stall_out=0, state IDLE.
REQ-022 hazard=1 with mem_write_in=1, val_rm_in=32'hDEAD_BEEF -> mem_write_out=0, val_rm_out=32'hDEAD_BEEF; freeze+hazard together -> outputs unchanged.
REQ-023 Macro off: EXE_MUL captured -> stall_out stays 0, next edge captures following instruction.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
// ID/EX pipeline register. It captures the decode-stage control and operand
// fields once per cycle, and inserts a bubble on hazard. A branch flush clears
// it. While freeze is high it holds its contents.
//
// Optional feature (macro ID_EX_MUL_STALL_EN): an EXE_MUL instruction stays in
// EX for MUL_CYCLES cycles. While it does, stall_out asks the upstream stages
// to hold. With the macro undefined, EXE_MUL is treated like any other command
// and stall_out is tied to 0.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 discard contents (branch taken)
//   freeze                global pipeline hold
//   hazard                load a bubble (control fields zero, data fields kept)
//   B/S/wb_en/mem_read/mem_write/exe_cmd _in   control-unit fields
//   pc/val_rn/val_rm/shift_operand/imm/signed_imm24/dest _in  data fields
//   *_out                 registered copies of the *_in fields
//   stall_out             upstream hold request while a multicycle MUL runs
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        freeze,
  input  logic        hazard,
  input  logic        B_in,
  input  logic        S_in,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [11:0] shift_operand_in,
  input  logic        imm_in,
  input  logic [23:0] signed_imm24_in,
  input  logic [3:0]  dest_in,
  output logic        B_out,
  output logic        S_out,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  exe_cmd_out,
  output logic [31:0] pc_out,
  output logic [31:0] val_rn_out,
  output logic [31:0] val_rm_out,
  output logic [11:0] shift_operand_out,
  output logic        imm_out,
  output logic [23:0] signed_imm24_out,
  output logic [3:0]  dest_out,
  output logic        stall_out
);

  // Reject an out-of-range occupancy at elaboration time
  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("id_ex_stage_reg: MUL_CYCLES must be in 1..15");
  end

  // High when the register must keep its current contents on this edge
  logic hold_c;

`ifdef ID_EX_MUL_STALL_EN
  localparam logic [3:0] EXE_MUL   = 4'b1010;
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_CYCLES - 1);
  localparam bit         MUL_MULTI = (MUL_CYCLES > 1);

  typedef enum logic {IDLE, MUL_WAIT} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;

  assign hold_c    = freeze | (state_q == MUL_WAIT);
  assign stall_out = (state_q == MUL_WAIT);

  // MUL occupancy FSM. It counts down the remaining EX cycles. A hazard bubble
  // never starts a MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else if (!freeze) begin
      case (state_q)
        MUL_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        end
        default: begin
          if (!hazard && (exe_cmd_in == EXE_MUL) && MUL_MULTI) begin
            state_q <= MUL_WAIT;
            cnt_q   <= MUL_LOAD;
          end
        end
      endcase
    end
  end
`else
  assign hold_c    = freeze;
  assign stall_out = 1'b0;
`endif

  // Pipeline register. On a hazard the control fields load as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      B_out             <= 1'b0;
      S_out             <= 1'b0;
      wb_en_out         <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
      exe_cmd_out       <= 4'd0;
      pc_out            <= 32'd0;
      val_rn_out        <= 32'd0;
      val_rm_out        <= 32'd0;
      shift_operand_out <= 12'd0;
      imm_out           <= 1'b0;
      signed_imm24_out  <= 24'd0;
      dest_out          <= 4'd0;
    end else if (!hold_c) begin
      B_out             <= B_in         & ~hazard;
      S_out             <= S_in         & ~hazard;
      wb_en_out         <= wb_en_in     & ~hazard;
      mem_read_out      <= mem_read_in  & ~hazard;
      mem_write_out     <= mem_write_in & ~hazard;
      exe_cmd_out       <= hazard ? 4'd0 : exe_cmd_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      shift_operand_out <= shift_operand_in;
      imm_out           <= imm_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_MUL = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n, flush, freeze, hazard;
  logic        B_in, S_in, wb_en_in, mem_read_in, mem_write_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm24_in;
  logic        B_out, S_out, wb_en_out, mem_read_out, mem_write_out, imm_out;
  logic [3:0]  exe_cmd_out, dest_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic        stall_out;

  int checks = 0;
  int errors = 0;

  id_ex_stage_reg #(.MUL_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze), .hazard(hazard),
    .B_in(B_in), .S_in(S_in), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .shift_operand_in(shift_operand_in), .imm_in(imm_in),
    .signed_imm24_in(signed_imm24_in), .dest_in(dest_in),
    .B_out(B_out), .S_out(S_out), .wb_en_out(wb_en_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .exe_cmd_out(exe_cmd_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
    .imm_out(imm_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  // All outputs (except stall_out) packed into one vector, 146 bits
  function automatic logic [159:0] all_out();
    return 160'({B_out, S_out, wb_en_out, mem_read_out, mem_write_out,
                 exe_cmd_out, pc_out, val_rn_out, val_rm_out,
                 shift_operand_out, imm_out, signed_imm24_out, dest_out});
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] cmd, input logic [3:0] dst,
                           input logic wb, input logic [31:0] rm);
    exe_cmd_in = cmd; dest_in = dst; wb_en_in = wb; val_rm_in = rm;
  endtask

  logic [159:0] snap;

  initial begin
    rst_n = 1'b0; flush = 1'b0; freeze = 1'b0; hazard = 1'b0;
    B_in = 1'b0; S_in = 1'b0; wb_en_in = 1'b0; mem_read_in = 1'b0;
    mem_write_in = 1'b0; imm_in = 1'b0; exe_cmd_in = 4'd0; dest_in = 4'd0;
    pc_in = 32'd0; val_rn_in = 32'd0; val_rm_in = 32'd0;
    shift_operand_in = 12'd0; signed_imm24_in = 24'd0;
    #12;
    chk("reset_outputs", all_out(), 160'd0);
    chk("reset_stall", 160'(stall_out), 160'd0);

    // Plain capture of an ADD
    rst_n = 1'b1;
    set_instr(EXE_ADD, 4'h3, 1'b1, 32'h0000_0011);
    pc_in = 32'h0000_0104; val_rn_in = 32'h1234_5678;
    step();
    chk("cap_exe_cmd", 160'(exe_cmd_out), 160'(EXE_ADD));
    chk("cap_dest", 160'(dest_out), 160'h3);
    chk("cap_wb_en", 160'(wb_en_out), 160'h1);
    chk("cap_stall", 160'(stall_out), 160'h0);
    chk("cap_pc_rn", 160'({pc_out, val_rn_out}), 160'({32'h0000_0104, 32'h1234_5678}));

    // Capture with every remaining field exercised
    B_in = 1'b1; S_in = 1'b1; mem_read_in = 1'b1; imm_in = 1'b1;
    shift_operand_in = 12'hABC; signed_imm24_in = 24'h80_0001;
    set_instr(EXE_SUB, 4'hC, 1'b0, 32'h5555_AAAA);
    step();
    chk("cap2_ctrl", 160'({B_out, S_out, wb_en_out, mem_read_out, mem_write_out, exe_cmd_out}),
        160'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, EXE_SUB}));
    chk("cap2_data", 160'({shift_operand_out, imm_out, signed_imm24_out, dest_out, val_rm_out}),
        160'({12'hABC, 1'b1, 24'h80_0001, 4'hC, 32'h5555_AAAA}));

    // Hazard: control fields bubble, data fields still load
    B_in = 1'b0; S_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b1;
    set_instr(EXE_ADD, 4'h6, 1'b1, 32'hDEAD_BEEF);
    hazard = 1'b1;
    step();
    chk("haz_mem_write", 160'(mem_write_out), 160'h0);
    chk("haz_ctrl", 160'({wb_en_out, exe_cmd_out}), 160'h0);
    chk("haz_val_rm", 160'(val_rm_out), 160'hDEAD_BEEF);
    chk("haz_dest", 160'(dest_out), 160'h6);

    // freeze together with hazard: everything holds
    snap = all_out();
    freeze = 1'b1;
    set_instr(EXE_SUB, 4'h9, 1'b1, 32'h0BAD_F00D);
    step();
    chk("freeze_hazard_hold", all_out(), snap);
    freeze = 1'b0; hazard = 1'b0; mem_write_in = 1'b0;

    // Asynchronous reset while outputs are nonzero
    set_instr(EXE_ADD, 4'hF, 1'b1, 32'hFFFF_0000);
    step();
    chk("pre_reset_nonzero", 160'(dest_out), 160'hF);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", all_out(), 160'd0);
    #3 rst_n = 1'b1;

`ifdef ID_EX_MUL_STALL_EN
    // MUL occupies EX for 3 cycles; stall high for 2
    set_instr(EXE_MUL, 4'h5, 1'b1, 32'h0000_0007);
    step();                                    // edge 0
    chk("mul_e0_cmd", 160'(exe_cmd_out), 160'(EXE_MUL));
    chk("mul_e0_stall", 160'(stall_out), 160'h1);
    set_instr(EXE_ADD, 4'h7, 1'b1, 32'h0000_0008);
    step();                                    // edge 1
    chk("mul_e1_hold", 160'({exe_cmd_out, dest_out, stall_out}), 160'({EXE_MUL, 4'h5, 1'b1}));
    step();                                    // edge 2
    chk("mul_e2_hold", 160'({exe_cmd_out, dest_out, stall_out}), 160'({EXE_MUL, 4'h5, 1'b0}));
    step();                                    // edge 3
    chk("mul_e3_next", 160'({exe_cmd_out, dest_out, stall_out}), 160'({EXE_ADD, 4'h7, 1'b0}));

    // freeze stretches MUL_WAIT; flush at cnt=1 clears everything
    set_instr(EXE_MUL, 4'h2, 1'b1, 32'h0000_0003);
    step();                                    // MUL captured, cnt=2
    freeze = 1'b1;
    step();
    chk("mul_freeze_stall", 160'({stall_out, dest_out}), 160'({1'b1, 4'h2}));
    freeze = 1'b0;
    step();                                    // cnt=1
    chk("mul_cnt1_stall", 160'(stall_out), 160'h1);
    flush = 1'b1;
    step();
    chk("flush_outputs", all_out(), 160'd0);
    chk("flush_stall", 160'(stall_out), 160'h0);
    flush = 1'b0;
    set_instr(EXE_ADD, 4'hA, 1'b1, 32'h0000_0001);
    step();
    chk("flush_then_idle_cap", 160'({exe_cmd_out, dest_out, stall_out}), 160'({EXE_ADD, 4'hA, 1'b0}));

    // Back-to-back MUL restarts without a gap cycle
    set_instr(EXE_MUL, 4'h1, 1'b1, 32'h0);
    step(); step(); step();                    // first MUL done
    set_instr(EXE_MUL, 4'h9, 1'b1, 32'h0);
    step();                                    // captured immediately after leaving
    chk("b2b_mul", 160'({exe_cmd_out, dest_out, stall_out}), 160'({EXE_MUL, 4'h9, 1'b1}));
    step(); step();
    chk("b2b_mul_end", 160'(stall_out), 160'h0);
`else
    // EXE_MUL is an ordinary command here
    set_instr(EXE_MUL, 4'h5, 1'b1, 32'h0000_0007);
    step();
    chk("mul_off_cmd", 160'({exe_cmd_out, dest_out, stall_out}), 160'({EXE_MUL, 4'h5, 1'b0}));
    set_instr(EXE_ADD, 4'h7, 1'b1, 32'h0000_0008);
    step();
    chk("mul_off_next", 160'({exe_cmd_out, dest_out, stall_out}), 160'({EXE_ADD, 4'h7, 1'b0}));
    flush = 1'b1;
    step();
    chk("flush_outputs", all_out(), 160'd0);
    flush = 1'b0;
`endif

    // MUL under hazard becomes a bubble and does not stall
    set_instr(EXE_MUL, 4'h4, 1'b1, 32'h0000_0042);
    hazard = 1'b1;
    step();
    chk("mul_hazard_bubble", 160'({exe_cmd_out, wb_en_out, dest_out, stall_out}),
        160'({4'h0, 1'b0, 4'h4, 1'b0}));
    hazard = 1'b0;
    set_instr(EXE_SUB, 4'hB, 1'b0, 32'h0000_0043);
    step();
    chk("after_mul_hazard", 160'({exe_cmd_out, dest_out, val_rm_out}),
        160'({EXE_SUB, 4'hB, 32'h0000_0043}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
